// File: rtl/act_seq_pkg.sv
// Shared types and constants for the activation LUT sequencer.
// The ACT_SEQ_WIDE_DIFF_EN build option is consumed by act_seq_interp.
package act_seq_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAC_W     = 4;
  localparam int LUT_AW     = 4;
  localparam int IDX_OFFSET = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_BASE = 3'd1,
    FETCH_NEXT = 3'd2,
    CALC       = 3'd3,
    RESP       = 3'd4
  } state_t;

  // Integer part of a signed Q4.4 operand shifted into the unsigned table range.
  function automatic logic [LUT_AW-1:0] lut_index(input logic [LUT_AW-1:0] int_part);
    return int_part + LUT_AW'(IDX_OFFSET);
  endfunction

endpackage

// File: rtl/act_seq_interp.sv
// Combinational linear interpolation between two adjacent table entries.
// ACT_SEQ_WIDE_DIFF_EN selects the exact widened datapath; default is the 8-bit wrapping one.
module act_seq_interp
  import act_seq_pkg::*;
(
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W-1:0] next,
  input  logic        [FRAC_W-1:0] remaining,
  output logic signed [DATA_W-1:0] value
);

`ifdef ACT_SEQ_WIDE_DIFF_EN
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W+4:0] prod;

  // Exact difference and product; the final sum is truncated back to the data width.
  always_comb begin
    diff  = {1'b0, {DATA_W{1'b0}}};
    prod  = {(DATA_W+5){1'b0}};
    value = {DATA_W{1'b0}};
    diff  = $signed({next[DATA_W-1], next}) - $signed({base[DATA_W-1], base});
    prod  = $signed({{4{diff[DATA_W]}}, diff}) * $signed({{(DATA_W+1){1'b0}}, remaining});
    value = DATA_W'($signed({{2{base[DATA_W-1]}}, base}) + $signed((DATA_W+2)'(prod >>> 4)));
  end
`else
  logic signed [DATA_W-1:0] diff;
  logic signed [DATA_W+3:0] prod;

  // Legacy datapath: the difference wraps at 8 bits, the product is kept whole ahead of the shift.
  always_comb begin
    diff  = {DATA_W{1'b0}};
    prod  = {(DATA_W+4){1'b0}};
    value = {DATA_W{1'b0}};
    diff  = next - base;
    prod  = $signed({{4{diff[DATA_W-1]}}, diff}) * $signed({{DATA_W{1'b0}}, remaining});
    value = base + DATA_W'(prod >>> 4);
  end
`endif

endmodule

// File: rtl/activation_lut_sequencer.sv
// Two-requester activation unit: round-robin arbiter, two-read LUT fetch FSM and
// interpolated response register. Build option ACT_SEQ_WIDE_DIFF_EN (see act_seq_interp).
module activation_lut_sequencer
  import act_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic                     req1_valid,
  input  logic        [DATA_W-1:0] req0_x,
  input  logic        [DATA_W-1:0] req1_x,
  output logic                     req0_ready,
  output logic                     req1_ready,
  output logic                     lut_rd_en,
  output logic        [LUT_AW-1:0] lut_addr,
  input  logic signed [DATA_W-1:0] lut_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic signed [DATA_W-1:0] rsp_value
);

  state_t                   state;
  state_t                   state_nxt;
  logic                     accept;
  logic                     grant_id;
  logic        [DATA_W-1:0] sel_x;
  logic        [DATA_W-1:0] x_r;
  logic                     id_r;
  logic                     last_r;
  logic signed [DATA_W-1:0] base_r;
  logic        [LUT_AW-1:0] idx;
  logic        [LUT_AW-1:0] idx_next;
  logic signed [DATA_W-1:0] interp_value;

  assign sel_x    = grant_id ? req1_x : req0_x;
  assign idx      = lut_index(x_r[DATA_W-1:FRAC_W]);
  assign idx_next = (idx == {LUT_AW{1'b1}}) ? idx : idx + {{(LUT_AW-1){1'b0}}, 1'b1};
  assign rsp_id   = id_r;

  act_seq_interp u_interp (
    .base      (base_r),
    .next      (lut_rdata),
    .remaining (x_r[FRAC_W-1:0]),
    .value     (interp_value)
  );

  // Next-state, arbitration and request handshake.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          accept   = 1'b1;
          grant_id = ~last_r;
        end else if (req0_valid) begin
          accept   = 1'b1;
          grant_id = 1'b0;
        end else if (req1_valid) begin
          accept   = 1'b1;
          grant_id = 1'b1;
        end else begin
          accept   = 1'b0;
          grant_id = 1'b0;
        end
        if (accept) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = FETCH_BASE;
        end else begin
          state_nxt  = IDLE;
        end
      end
      FETCH_BASE: state_nxt = FETCH_NEXT;
      FETCH_NEXT: state_nxt = CALC;
      CALC:       state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // State, operand capture, table addressing and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      x_r       <= {DATA_W{1'b0}};
      id_r      <= 1'b0;
      last_r    <= 1'b1;
      base_r    <= {DATA_W{1'b0}};
      lut_rd_en <= 1'b0;
      lut_addr  <= {LUT_AW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_value <= {DATA_W{1'b0}};
    end else begin
      state     <= state_nxt;
      lut_rd_en <= (state_nxt == FETCH_BASE) || (state_nxt == FETCH_NEXT);
      case (state)
        IDLE: begin
          if (accept) begin
            x_r      <= sel_x;
            id_r     <= grant_id;
            last_r   <= grant_id;
            lut_addr <= lut_index(sel_x[DATA_W-1:FRAC_W]);
          end
        end
        FETCH_BASE: lut_addr <= idx_next;
        FETCH_NEXT: base_r   <= lut_rdata;
        CALC: begin
          rsp_value <= interp_value;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_lut_sequencer.sv
// Directed self-checking bench for activation_lut_sequencer with a behavioural LUT (lut[i] = 16*i - 128).
module tb_activation_lut_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic        [7:0] req0_x, req1_x;
  logic              req0_ready, req1_ready;
  logic              lut_rd_en;
  logic        [3:0] lut_addr;
  logic signed [7:0] lut_rdata;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic signed [7:0] rsp_value;

  logic signed [7:0] lut_mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  activation_lut_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_x(req0_x), .req1_x(req1_x),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .lut_rd_en(lut_rd_en), .lut_addr(lut_addr), .lut_rdata(lut_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_value(rsp_value)
  );

  // Single-port table: data appears the cycle after the read enable.
  always_ff @(posedge clk) begin
    if (lut_rd_en) lut_rdata <= lut_mem[lut_addr];
  end

  task automatic load_lut();
    for (int i = 0; i < 16; i++) lut_mem[i] = 8'(16 * i - 128);
  endtask

  task automatic test_reset();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = 8'h00; req1_x = 8'h00; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_value !== 8'sd0) begin errors++; $display("FAIL reset_rsp_value got %0d want 0", rsp_value); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
    checks++; if (lut_rd_en !== 1'b0) begin errors++; $display("FAIL reset_lut_rd_en got %b want 0", lut_rd_en); end
    checks++; if (lut_addr !== 4'd0) begin errors++; $display("FAIL reset_lut_addr got %0d want 0", lut_addr); end
    rst = 1'b1;
  endtask

  task automatic serve(input logic id, input logic [7:0] x, input logic [3:0] a0,
                       input logic [3:0] a1, input logic signed [7:0] expv, input string nm);
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_x = x; end
    else    begin req0_valid = 1'b1; req0_x = x; end
    #1;
    checks++; if ((id ? req1_ready : req0_ready) !== 1'b1 || (id ? req0_ready : req1_ready) !== 1'b0) begin
      errors++; $display("FAIL %s_grant got r0=%b r1=%b want id %b", nm, req0_ready, req1_ready, id); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (lut_rd_en !== 1'b1 || lut_addr !== a0) begin
      errors++; $display("FAIL %s_addr_base got en=%b addr=%0d want en=1 addr=%0d", nm, lut_rd_en, lut_addr, a0); end
    @(negedge clk);
    checks++; if (lut_rd_en !== 1'b1 || lut_addr !== a1) begin
      errors++; $display("FAIL %s_addr_next got en=%b addr=%0d want en=1 addr=%0d", nm, lut_rd_en, lut_addr, a1); end
    @(negedge clk);
    checks++; if (lut_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_calc got en=%b rsp_valid=%b want 0 0", nm, lut_rd_en, rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_value !== expv || rsp_id !== id) begin
      errors++; $display("FAIL %s_rsp got v=%b val=%0d id=%b want v=1 val=%0d id=%b",
                         nm, rsp_valid, rsp_value, rsp_id, expv, id); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_rsp_drop got %b want 0", nm, rsp_valid); end
  endtask

  task automatic test_interp();
    serve(1'b0, 8'h00, 4'd8, 4'd9, 8'sd0, "zero");
    serve(1'b1, 8'h18, 4'd9, 4'd10, 8'sd24, "mid");
    serve(1'b0, 8'h7F, 4'd15, 4'd15, 8'sd112, "sat");
  endtask

  task automatic test_wide_diff();
    logic signed [7:0] expv;
`ifdef ACT_SEQ_WIDE_DIFF_EN
    expv = 8'sd0;
`else
    expv = -8'sd128;
`endif
    lut_mem[9] = -8'sd100;
    lut_mem[10] = 8'sd100;
    serve(1'b0, 8'h18, 4'd9, 4'd10, expv, "diff");
    load_lut();
  endtask

  task automatic test_back_to_back();
    logic exp_id [3];
    logic signed [7:0] exp_val [3];
    logic found;
    int lat;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
    exp_val[0] = 8'sd24; exp_val[1] = 8'sd0; exp_val[2] = 8'sd24;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0_x = 8'h18; req1_x = 8'h00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (req0_ready || req1_ready) begin found = 1'b1; break; end
        @(negedge clk); #1;
      end
      checks++; if (!found || req1_ready !== exp_id[g] || req0_ready !== ~exp_id[g]) begin
        errors++; $display("FAIL rr_grant%0d got r0=%b r1=%b want id %b", g, req0_ready, req1_ready, exp_id[g]); end
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rr_latency%0d got %0d want 4", g, lat); end
      checks++; if (rsp_id !== exp_id[g] || rsp_value !== exp_val[g]) begin
        errors++; $display("FAIL rr_rsp%0d got id=%b val=%0d want id=%b val=%0d",
                           g, rsp_id, rsp_value, exp_id[g], exp_val[g]); end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_value !== exp_val[g] || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++; $display("FAIL rr_hold%0d got v=%b val=%0d r0=%b r1=%b want v=1 val=%0d no ready",
                             g, rsp_valid, rsp_value, req0_ready, req1_ready, exp_val[g]); end
      end
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      rsp_ready = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req1_valid = 1'b1; req1_x = 8'h18;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_grant got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || rsp_value !== 8'sd0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL mid_reset_rsp got v=%b val=%0d id=%b want 0 0 0", rsp_valid, rsp_value, rsp_id); end
    checks++; if (lut_rd_en !== 1'b0 || lut_addr !== 4'd0) begin
      errors++; $display("FAIL mid_reset_lut got en=%b addr=%0d want 0 0", lut_rd_en, lut_addr); end
    serve(1'b1, 8'h7F, 4'd15, 4'd15, 8'sd112, "post_reset");
  endtask

  initial begin
    load_lut();
    test_reset();
    test_interp();
    test_wide_diff();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_lut_sequencer.md
ACTIVATION_LUT_SEQUENCER -- requirements
Module: activation_lut_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: req0_valid / req1_valid  in  1 each  requester has an operand pending.
REQ-004 SHALL have ports: req0_x / req1_x  in  8 each  signed Q4.4 operand.
REQ-005 SHALL have ports: req0_ready / req1_ready  out  1 each  operand accepted this cycle.
REQ-006 SHALL have ports: lut_rd_en  out  1, lut_addr  out  4, lut_rdata  in  8 signed; single-port table, rdata valid the cycle after rd_en.
REQ-007 SHALL have ports: rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  1 (served requester), rsp_value  out  8 signed.

Function
REQ-008 SHALL use FSM states IDLE, FETCH_BASE, FETCH_NEXT, CALC, RESP.
REQ-009 IDLE: reqN_ready = 1 combinationally only for the granted valid requester; on that cycle latch x and id, go to FETCH_BASE.
REQ-010 Arbitration SHALL be round-robin: if both valid, grant the requester not served last; if one valid, grant it.
REQ-011 Index SHALL be idx = x[7:4] + 8 (mod 16); remaining = x[3:0] unsigned.
REQ-012 FETCH_BASE: lut_rd_en=1, lut_addr=idx; next state FETCH_NEXT.
REQ-013 FETCH_NEXT: capture lut_rdata as base; lut_rd_en=1, lut_addr = idx+1, saturated at 15 (idx=15 rereads 15); next state CALC.
REQ-014 CALC: capture lut_rdata as next, register result; next state RESP.
REQ-015 Result SHALL be base + (((next - base) * remaining) >>> 4), signed arithmetic shift.
REQ-016 RESP: rsp_valid=1 with stable rsp_id and rsp_value until rsp_ready=1; on that handshake go to IDLE.
REQ-017 Latency: rsp_valid SHALL rise exactly 4 cycles after the accept cycle; throughput at most one operand per 5 cycles.
REQ-018 No requests are accepted outside IDLE; reqN_ready SHALL be 0 in all other states.
REQ-019 lut_rd_en SHALL be 0 outside FETCH_BASE and FETCH_NEXT; lut_addr holds its last value.

Reset
REQ-020 When rst=0 at a clock edge, the block SHALL enter IDLE, even mid-operation, discarding any operation in progress.
REQ-021 Reset values SHALL be rsp_valid=0, rsp_value=0, rsp_id=0, lut_rd_en=0, lut_addr=0.
REQ-022 Reset SHALL set the last-served pointer to 1, so req0 wins the first contention.

Configuration
REQ-023 Macro ACT_SEQ_WIDE_DIFF_EN: defined -> difference taken in 9 bits, product 13 bits, sum 10 bits, truncated to 8 bits; exact, never overflows since remaining<=15.
REQ-024 Macro ACT_SEQ_WIDE_DIFF_EN: undefined -> all arithmetic in 8 bits with wrap, bit-identical to the existing interpolator datapath.

Structure
REQ-025 Package act_seq_pkg SHALL hold the FSM state enum and constants DATA_W=8, FRAC_W=4, LUT_AW=4, IDX_OFFSET=8.
REQ-026 Sub-module act_seq_interp SHALL implement the REQ-015 arithmetic combinationally (base, next, remaining -> value), including the macro selection; the top holds FSM, arbiter and registers.

Verification (LUT model lut[i] = 16*i - 128)
REQ-027 req0 x=0x00 -> lut_addr 8 then 9; rsp_value=0, rsp_id=0, rsp_valid 4 cycles after accept.
REQ-028 req1 x=0x18 -> addrs 9,10; base 16, next 32, rem 8 -> rsp_value=24, rsp_id=1.
REQ-029 x=0x7F -> addrs 15,15; rsp_value=112 (upper-boundary saturation of idx+1).
REQ-030 Both valid continuously after reset -> grants alternate: req0, req1, req0; rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_value stable, no new accept.
REQ-031 Forced base=-100, next=100, rem=8 -> rsp_value=0 with ACT_SEQ_WIDE_DIFF_EN, -128 without.
REQ-032 rst=0 during CALC -> next cycle IDLE, rsp_valid=0, outputs zero; a following req1-only request is served normally.
